// File: rtl/d16_pkg.sv
// rtl/d16_pkg.sv - shared FSM encoding and constants for the d16 pipeline controller
package d16_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } d16_state_t;

  // Byte distance between consecutive instructions.
  localparam int D16_STEP = 4;

endpackage

// File: rtl/d16_sat_cnt.sv
// rtl/d16_sat_cnt.sv - saturating event counter with synchronous clear
module d16_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // Count up on inc and stick at all-ones; clear takes precedence over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/d16_pipe_ctrl.sv
// rtl/d16_pipe_ctrl.sv - fetch/stall/redirect/drain control for a d16 instruction pipeline
module d16_pipe_ctrl
  import d16_pkg::*;
#(
  parameter int AW        = 16,
  parameter int STAGES    = 4,
  parameter int JMP_STAGE = 1,
  parameter int STEP      = D16_STEP,
  parameter int CW        = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic [AW-1:0]     ins_a,
  output logic              ins_req,
  input  logic              ins_ack,
  input  logic              data_stall,
  input  logic              hazard,
  input  logic              jmp_load,
  input  logic [AW-1:0]     jmp_adr,
  input  logic              halt,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [AW-1:0]     ip,
  output logic              halted,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  d16_state_t        state;
  d16_state_t        next_state;
  logic              active;
  logic              redirect;
  logic              hazard_acc;
  logic              fetch;
  logic              stall_inc;
  logic [STAGES-1:0] valid_next;
  logic [AW-1:0]     ip_next;

  // Decide which event owns this cycle: data_stall, then redirect, then hazard.
  always_comb begin
    active     = (state == ST_RUN) || (state == ST_DRAIN);
    redirect   = active && !data_stall && jmp_load && stage_valid[JMP_STAGE];
    hazard_acc = active && !data_stall && !redirect && hazard;
    fetch      = (state == ST_RUN) && ins_ack;
    stall_inc  = data_stall || hazard_acc;
  end

  // Fetch address and register enables react to this cycle's inputs directly.
  always_comb begin
    ins_a    = redirect ? jmp_adr : ip;
    stage_en = '0;
    if (active && !data_stall) begin
      stage_en = '1;
      if (hazard_acc) begin
        stage_en[0] = 1'b0;
      end
    end
  end

  // Movement of valid bits and the sequential fetch pointer for this cycle.
  always_comb begin
    valid_next = stage_valid;
    ip_next    = ip;
    if (active && !data_stall) begin
      valid_next = {stage_valid[STAGES-2:0], fetch};
      if (redirect) begin
        valid_next[JMP_STAGE:0] = '0;
        ip_next                 = jmp_adr + STEP_A;
      end else if (hazard_acc) begin
        valid_next[0] = stage_valid[0];
        valid_next[1] = 1'b0;
      end else if (fetch) begin
        ip_next = ip + STEP_A;
      end
    end
  end

  // Next state; data_stall freezes the FSM, DRAIN ends once nothing valid remains.
  always_comb begin
    next_state = state;
    if (!data_stall) begin
      case (state)
        ST_BOOT:   next_state = ST_RUN;
        ST_RUN:    if (halt) next_state = ST_DRAIN;
        ST_DRAIN: begin
          if (!halt) begin
            next_state = ST_RUN;
          end else if (valid_next == '0) begin
            next_state = ST_HALTED;
          end
        end
        ST_HALTED: if (!halt) next_state = ST_RUN;
        default:   next_state = ST_BOOT;
      endcase
    end
  end

  // State, pointer, valid bits and status flags; flags are registered from next_state.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= ST_BOOT;
      ip          <= '0;
      stage_valid <= '0;
      ins_req     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= next_state;
      ip          <= ip_next;
      stage_valid <= valid_next;
      ins_req     <= (next_state == ST_RUN);
      halted      <= (next_state == ST_HALTED);
    end
  end

  d16_sat_cnt #(.CW(CW)) u_stall_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  d16_sat_cnt #(.CW(CW)) u_flush_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .clear (1'b0),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: doc/d16_pipe_ctrl.md
D16_PIPE_CTRL -- requirements
Module: d16_pipe_ctrl

Interface
REQ-001 Parameter AW, default 16: instruction address width.
REQ-002 Parameter STAGES, default 4: number of pipeline registers; register 0 is the fetch/decode register.
REQ-003 Parameter JMP_STAGE, default 1: index of the register whose instruction resolves jumps; legal range 0..STAGES-2.
REQ-004 Parameter STEP, default 4: byte increment between instructions.
REQ-005 Parameter CW, default 16: width of the performance counters.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports SHALL be as follows:
  - sys_clk  in  1  clock.
  - sys_rst  in  1  asynchronous, active-low reset.
  - ins_a  out  AW  fetch address.
  - ins_req  out  1  fetch request.
  - ins_ack  in  1  instruction word valid this cycle.
  - data_stall  in  1  memory stage not complete.
  - hazard  in  1  register-0 instruction depends on an in-flight result.
  - jmp_load  in  1  jump taken.
  - jmp_adr  in  AW  jump target.
  - halt  in  1  drain-and-stop request.
  - stage_en  out  STAGES  per-register enable.
  - stage_valid  out  STAGES  per-register valid.
  - ip  out  AW  next sequential fetch address.
  - halted  out  1  pipeline empty and stopped.
  - stall_cnt  out  CW  stall-cycle counter.
  - flush_cnt  out  CW  redirect counter.

Function
REQ-008 The FSM SHALL have states BOOT, RUN, DRAIN and HALTED; BOOT SHALL last exactly one cycle with ins_req=0, then go to RUN.
REQ-009 In RUN, ins_req SHALL be 1, and ins_a SHALL equal jmp_adr when a redirect is accepted, else ip.
REQ-010 Priority per cycle SHALL be, highest first: data_stall, redirect, hazard, missing ins_ack.
REQ-011 data_stall=1: stage_en=0 on all bits, and stage_valid, ip, state and ins_a SHALL hold; jmp_load is ignored that cycle.
REQ-012 Redirect is accepted when jmp_load=1, stage_valid[JMP_STAGE]=1 and data_stall=0. On acceptance:
  - ip <= jmp_adr+STEP, computed modulo 2^AW;
  - stage_valid[0..JMP_STAGE] <= 0 next cycle;
  - older stages advance;
  - flush_cnt increments.
REQ-013 hazard=1 without redirect: stage_en[0]=0 and ip holds; stage_valid[1] <= 0 (bubble); stages 2..STAGES-1 advance.
REQ-014 ins_ack=0 in RUN with no higher event: stage_valid[0] <= 0, ip holds, all other stages advance.
REQ-015 Normal advance: stage_en all 1; stage_valid[0] <= ins_ack; stage_valid[k] <= stage_valid[k-1]; ip <= ip+STEP, wrapping at 2^AW.
REQ-016 halt=1 in RUN SHALL move the FSM to DRAIN. In DRAIN:
  - ins_req=0 and stage_valid[0] <= 0;
  - a redirect SHALL still update ip;
  - when all stage_valid bits are 0, the FSM SHALL enter HALTED.
REQ-017 HALTED: halted=1, ins_req=0, stage_en=0; halt=0 SHALL return to RUN on the next cycle, fetching from ip.
REQ-018 halt deasserted during DRAIN SHALL return to RUN immediately, without entering HALTED.
REQ-019 stall_cnt SHALL increment on each cycle with data_stall=1 or an accepted hazard; flush_cnt SHALL increment on each accepted redirect; both SHALL saturate at 2^CW-1.
REQ-020 stage_en and ins_a SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-021 sys_rst=0 SHALL immediately force:
  - state to BOOT;
  - ip, ins_a, stage_valid, stall_cnt and flush_cnt to 0;
  - halted to 0, ins_req to 0, stage_en to 0.
REQ-022 Reset asserted mid-redirect, stall or drain SHALL discard that operation entirely; no counter update SHALL survive.

Structure
REQ-023 The state encoding and the default STEP constant SHALL live in the shared package d16_pkg.
REQ-024 Both counters SHALL be instances of one sub-module, d16_sat_cnt (parameter CW; inputs inc and clear).

Verification
REQ-025 Reset release, ins_ack=1 constant -> ins_req=0 for 1 cycle; ins_a sequence 0, 4, 8, C; stage_valid fills 0001, 0011, 0111, 1111.
REQ-026 jmp_load=1, jmp_adr=0x0100 with stage_valid[1]=1 -> ins_a=0x0100 that cycle; ip=0x0104 next; stage_valid[1:0]=00; flush_cnt=1.
REQ-027 data_stall=1 for 3 cycles, with jmp_load=1 on cycle 2 -> everything frozen, stall_cnt=3; redirect accepted on the first cycle after data_stall falls.
REQ-028 hazard=1 for 1 cycle at ip=0x0010 -> ip holds 0x0010; stage_valid[1]=0 next cycle; stall_cnt +1.
REQ-029 halt=1 with a full pipeline (STAGES=4) -> halted=1 after 4 cycles with no new fetch; halt=0 -> fetch resumes at the held ip.
REQ-030 AW=8, ip=0xFC, normal advance -> ip=0x00. CW=2 with 5 stall cycles -> stall_cnt=3.
